// File: rtl/clock_time_keeper.sv
// clock_time_keeper
//   Time-of-day keeper. Divides clk down to a once-per-second tick and keeps
//   hours/minutes/seconds plus a seconds-of-day count for the display and
//   format logic downstream. A three-button set mode lets the user edit the
//   hours and the minutes.
//
// Parameters
//   CLK_HZ      input clock frequency in Hz (>= 2); one second = CLK_HZ cycles
//   HOURS_DAY   hour wrap value (<= 24); hours count 0..HOURS_DAY-1
//
// Ports
//   clk         in   1   system clock, all logic on posedge
//   reset_n     in   1   asynchronous, active-low reset
//   buttons     in   3   [0]=mode, [1]=up, [2]=down; already synchronised and
//                        debounced, level sensitive
//   hours       out  5   current hour
//   minutes     out  6   current minute
//   seconds     out  6   current second
//   sec_of_day  out  17  3600*hours + 60*minutes + seconds, one cycle behind
//   tick_1hz    out  1   one-cycle pulse per elapsed second (RUN only)
//   set_mode    out  2   2'b00 RUN, 2'b01 SET_HOUR, 2'b10 SET_MIN

module clock_time_keeper #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int HOURS_DAY = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  buttons,
    output logic [4:0]  hours,
    output logic [5:0]  minutes,
    output logic [5:0]  seconds,
    output logic [16:0] sec_of_day,
    output logic        tick_1hz,
    output logic [1:0]  set_mode
);

    localparam int              PW       = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PRESC_TC = PW'(CLK_HZ - 1);
    localparam logic [4:0]      HOUR_MAX = 5'(HOURS_DAY - 1);
    localparam logic [5:0]      MIN_MAX  = 6'd59;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } mode_e;

    mode_e          state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [4:0]     hours_q, hours_d;
    logic [5:0]     minutes_q, minutes_d;
    logic [5:0]     seconds_q, seconds_d;
    logic [16:0]    sod_q, sod_d;
    logic           tick_q, tick_d;
    logic [2:0]     buttons_q;

    logic [2:0]     press;
    logic           modeReq;
    logic           incReq;
    logic           decReq;

    // A press is the first cycle a button reads high; holding it does nothing more.
    // Up and down together cancel each other out.
    assign press   = buttons & ~buttons_q;
    assign modeReq = press[0];
    assign incReq  = press[1] & ~press[2];
    assign decReq  = press[2] & ~press[1];

    // Next-state logic: the prescaler and carry chain run only in RUN; in the
    // set states the prescaler is parked at 0 so leaving SET_MIN starts a
    // full second. A mode press always takes priority over up/down.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        tick_d    = 1'b0;
        sod_d     = 17'(hours_q) * 17'd3600 + 17'(minutes_q) * 17'd60 + 17'(seconds_q);

        case (state_q)
            RUN: begin
                if (presc_q == PRESC_TC) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    if (seconds_q == MIN_MAX) begin
                        seconds_d = '0;
                        if (minutes_q == MIN_MAX) begin
                            minutes_d = '0;
                            hours_d   = (hours_q == HOUR_MAX) ? 5'd0 : hours_q + 5'd1;
                        end else begin
                            minutes_d = minutes_q + 6'd1;
                        end
                    end else begin
                        seconds_d = seconds_q + 6'd1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
                // A mode press on the terminal-count cycle still lets that second count.
                if (modeReq) begin
                    state_d = SET_HOUR;
                    presc_d = '0;
                end
            end

            SET_HOUR: begin
                presc_d = '0;
                if (modeReq) begin
                    state_d = SET_MIN;
                end else if (incReq) begin
                    hours_d = (hours_q == HOUR_MAX) ? 5'd0 : hours_q + 5'd1;
                end else if (decReq) begin
                    hours_d = (hours_q == 5'd0) ? HOUR_MAX : hours_q - 5'd1;
                end
            end

            SET_MIN: begin
                presc_d = '0;
                if (modeReq) begin
                    state_d   = RUN;
                    seconds_d = '0;
                end else if (incReq) begin
                    minutes_d = (minutes_q == MIN_MAX) ? 6'd0 : minutes_q + 6'd1;
                end else if (decReq) begin
                    minutes_d = (minutes_q == 6'd0) ? MIN_MAX : minutes_q - 6'd1;
                end
            end

            default: begin
                state_d = RUN;
                presc_d = '0;
            end
        endcase
    end

    // State registers; reset clears the time and abandons any edit in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RUN;
            presc_q   <= '0;
            hours_q   <= '0;
            minutes_q <= '0;
            seconds_q <= '0;
            sod_q     <= '0;
            tick_q    <= 1'b0;
            buttons_q <= '0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            seconds_q <= seconds_d;
            sod_q     <= sod_d;
            tick_q    <= tick_d;
            buttons_q <= buttons;
        end
    end

    assign hours      = hours_q;
    assign minutes    = minutes_q;
    assign seconds    = seconds_q;
    assign sec_of_day = sod_q;
    assign tick_1hz   = tick_q;
    assign set_mode   = state_q;

endmodule

// File: tb/tb_clock_time_keeper.sv
// tb_clock_time_keeper
//   Directed bench for clock_time_keeper with a 10-cycle second. Inputs are
//   driven 1 ns after a rising edge and outputs are sampled at that moment too,
//   so every value read has settled from the edge just before.

module tb_clock_time_keeper;

    logic        clk;
    logic        reset_n;
    logic [2:0]  buttons;
    logic [4:0]  hours;
    logic [5:0]  minutes;
    logic [5:0]  seconds;
    logic [16:0] sec_of_day;
    logic        tick_1hz;
    logic [1:0]  set_mode;

    int checks;
    int failures;

    clock_time_keeper #(
        .CLK_HZ    (10),
        .HOURS_DAY (24)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .buttons    (buttons),
        .hours      (hours),
        .minutes    (minutes),
        .seconds    (seconds),
        .sec_of_day (sec_of_day),
        .tick_1hz   (tick_1hz),
        .set_mode   (set_mode)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case the stimulus sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Checks the whole visible time/state bundle except sec_of_day.
    task automatic checkTime(input string tag, input int expH, input int expM,
                             input int expS, input int expTick, input int expMode);
        checkOutput({tag, ".hours"},    32'(hours),    32'(expH));
        checkOutput({tag, ".minutes"},  32'(minutes),  32'(expM));
        checkOutput({tag, ".seconds"},  32'(seconds),  32'(expS));
        checkOutput({tag, ".tick"},     32'(tick_1hz), 32'(expTick));
        checkOutput({tag, ".set_mode"}, 32'(set_mode), 32'(expMode));
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One button press: assert for one edge, release for one edge.
    task automatic applyStimulus(input logic [2:0] b);
        buttons = b;
        waitCycles(1);
        buttons = 3'b000;
        waitCycles(1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        buttons  = 3'b000;

        // Reset state
        #2;
        checkTime("reset", 0, 0, 0, 0, 0);
        checkOutput("reset.sod", 32'(sec_of_day), 32'd0);
        #15;
        reset_n = 1'b1;

        // Test 1: free run for 30 cycles, tick every 10, sec_of_day one cycle late
        for (int c = 1; c <= 30; c++) begin
            waitCycles(1);
            checkOutput($sformatf("run%0d.tick", c), 32'(tick_1hz), (c % 10 == 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("run%0d.sec", c), 32'(seconds), 32'(c / 10));
            checkOutput($sformatf("run%0d.sod", c), 32'(sec_of_day), 32'((c - 1) / 10));
        end

        // Test 2: set 23:59, resume, run through midnight
        applyStimulus(3'b001);
        checkTime("enterSetHour", 0, 0, 3, 0, 1);
        for (int i = 0; i < 23; i++) applyStimulus(3'b010);
        checkTime("hour23", 23, 0, 3, 0, 1);
        applyStimulus(3'b001);
        for (int i = 0; i < 59; i++) applyStimulus(3'b010);
        checkTime("min59", 23, 59, 3, 0, 2);
        applyStimulus(3'b001);
        checkTime("exitSet", 23, 59, 0, 0, 0);
        checkOutput("exitSet.sod", 32'(sec_of_day), 32'd86340);
        waitCycles(9);
        checkTime("firstTick", 23, 59, 1, 1, 0);
        waitCycles(580);
        checkTime("at235959", 23, 59, 59, 1, 0);
        waitCycles(1);
        checkOutput("sod86399", 32'(sec_of_day), 32'd86399);
        checkOutput("tickLow", 32'(tick_1hz), 32'd0);
        waitCycles(9);
        checkTime("midnight", 0, 0, 0, 1, 0);
        checkOutput("midnight.sodLag", 32'(sec_of_day), 32'd86399);
        waitCycles(1);
        checkOutput("midnight.sod", 32'(sec_of_day), 32'd0);

        // Test 3: hour wrap in both directions, no ticks while editing
        applyStimulus(3'b001);
        checkTime("setHour2", 0, 0, 0, 0, 1);
        applyStimulus(3'b100);
        checkTime("downWrap", 23, 0, 0, 0, 1);
        applyStimulus(3'b010);
        checkTime("upWrap", 0, 0, 0, 0, 1);
        for (int i = 0; i < 12; i++) begin
            waitCycles(1);
            checkOutput($sformatf("frozen%0d.tick", i), 32'(tick_1hz), 32'd0);
        end
        checkTime("frozen", 0, 0, 0, 0, 1);

        // Test 4: up+down cancels, mode beats up
        for (int i = 0; i < 5; i++) applyStimulus(3'b010);
        checkTime("hour5", 5, 0, 0, 0, 1);
        applyStimulus(3'b110);
        checkTime("upDown", 5, 0, 0, 0, 1);
        applyStimulus(3'b011);
        checkTime("modeUp", 5, 0, 0, 0, 2);

        // Test 5: minute wrap, then a held button counts once
        applyStimulus(3'b100);
        checkTime("minDownWrap", 5, 59, 0, 0, 2);
        applyStimulus(3'b010);
        checkTime("minUpWrap", 5, 0, 0, 0, 2);
        buttons = 3'b010;
        waitCycles(8);
        checkTime("heldUp", 5, 1, 0, 0, 2);
        buttons = 3'b000;
        waitCycles(1);
        for (int i = 0; i < 16; i++) applyStimulus(3'b010);
        checkTime("min17", 5, 17, 0, 0, 2);

        // Test 6: asynchronous reset mid-cycle while editing
        #3;
        reset_n = 1'b0;
        #1;
        checkTime("asyncReset", 0, 0, 0, 0, 0);
        checkOutput("asyncReset.sod", 32'(sec_of_day), 32'd0);
        #2;
        reset_n = 1'b1;

        // Mode press on the terminal-count edge: second counts, then SET_HOUR
        waitCycles(9);
        checkTime("preTc", 0, 0, 0, 0, 0);
        buttons = 3'b001;
        waitCycles(1);
        checkTime("modeAtTc", 0, 0, 1, 1, 1);
        buttons = 3'b000;
        waitCycles(1);
        checkOutput("modeAtTc.sod", 32'(sec_of_day), 32'd1);
        checkOutput("modeAtTc.tickLow", 32'(tick_1hz), 32'd0);
        waitCycles(15);
        checkTime("afterTcFrozen", 0, 0, 1, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
